// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider: run request,
// config load, divided output and the strobes derived from it.
`timescale 1ns/1ps
interface clk_div_prog_if #(
  parameter int P_CNT_W = 16
);
  logic               en;
  logic               cfg_load;
  logic [P_CNT_W-1:0] cfg_div;
  logic [P_CNT_W-1:0] cfg_high;
  logic               clk_div;
  logic               rise;
  logic               fall;
  logic               period_end;
  logic               cfg_pending;
  logic               active;

  modport master (
    output en, cfg_load, cfg_div, cfg_high,
    input  clk_div, rise, fall, period_end, cfg_pending, active
  );

  modport slave (
    input  en, cfg_load, cfg_div, cfg_high,
    output clk_div, rise, fall, period_end, cfg_pending, active
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable divider: period N >= 2, high time H in 0..N, with
// rise/fall/period-end strobes and config changes only at period boundaries.
`timescale 1ns/1ps
module clk_div_prog #(
  parameter int P_CNT_W        = 16,
  parameter int P_DIV_DEFAULT  = 2,
  parameter int P_HIGH_DEFAULT = 1,
  parameter int P_EN_DEFAULT   = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  clk_div_prog_if.slave ctrl
);
  localparam logic [P_CNT_W-1:0] ONE       = P_CNT_W'(1);
  localparam logic [P_CNT_W-1:0] TWO       = P_CNT_W'(2);
  localparam logic [P_CNT_W-1:0] DIV_RST   = P_CNT_W'(P_DIV_DEFAULT);
  localparam logic [P_CNT_W-1:0] HIGH_RST  = P_CNT_W'(P_HIGH_DEFAULT);
  localparam logic               START_RST = (P_EN_DEFAULT != 0);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             state_reg, state_next;
  logic [P_CNT_W-1:0] cnt_reg, cnt_next;
  logic [P_CNT_W-1:0] div_reg, div_next;
  logic [P_CNT_W-1:0] high_reg, high_next;
  logic [P_CNT_W-1:0] shadow_div_reg, shadow_div_next;
  logic [P_CNT_W-1:0] shadow_high_reg, shadow_high_next;
  logic               pending_reg, pending_next;
  logic               start_reg;
  logic               clk_div_reg, clk_div_next;
  logic               rise_reg, rise_next;
  logic               fall_reg, fall_next;
  logic               period_end_reg, period_end_next;
  logic [P_CNT_W-1:0] load_div, load_high;
  logic               at_end, apply_cfg;

  // Clamp at capture so the active config is always a legal N/H pair.
  always_comb begin
    load_div  = (ctrl.cfg_div < TWO) ? TWO : ctrl.cfg_div;
    load_high = (ctrl.cfg_high > load_div) ? load_div : ctrl.cfg_high;
  end

  assign at_end    = (state_reg == ST_RUN) && (cnt_reg == div_reg - ONE);
  // A load in the boundary cycle itself waits for the following boundary.
  assign apply_cfg = pending_reg && !ctrl.cfg_load &&
                     ((state_reg == ST_IDLE) || at_end);

  always_comb begin
    div_next         = div_reg;
    high_next        = high_reg;
    shadow_div_next  = shadow_div_reg;
    shadow_high_next = shadow_high_reg;
    pending_next     = pending_reg;
    if (apply_cfg) begin
      div_next     = shadow_div_reg;
      high_next    = shadow_high_reg;
      pending_next = 1'b0;
    end
    if (ctrl.cfg_load) begin
      shadow_div_next  = load_div;
      shadow_high_next = load_high;
      pending_next     = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start_reg && ctrl.en) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (at_end) begin
          if (!ctrl.en) state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next count/config so they line up with cnt.
  always_comb begin
    clk_div_next    = 1'b0;
    rise_next       = 1'b0;
    fall_next       = 1'b0;
    period_end_next = 1'b0;
    if (state_next == ST_RUN) begin
      clk_div_next    = (cnt_next < high_next);
      rise_next       = (cnt_next == '0) && (high_next != '0) && !clk_div_reg;
      fall_next       = (cnt_next == high_next) && (high_next != '0) &&
                        (high_next < div_next);
      period_end_next = (cnt_next == div_next - ONE);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      div_reg         <= DIV_RST;
      high_reg        <= HIGH_RST;
      shadow_div_reg  <= DIV_RST;
      shadow_high_reg <= HIGH_RST;
      pending_reg     <= 1'b0;
      start_reg       <= START_RST;
      clk_div_reg     <= 1'b0;
      rise_reg        <= 1'b0;
      fall_reg        <= 1'b0;
      period_end_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      div_reg         <= div_next;
      high_reg        <= high_next;
      shadow_div_reg  <= shadow_div_next;
      shadow_high_reg <= shadow_high_next;
      pending_reg     <= pending_next;
      start_reg       <= ctrl.en;
      clk_div_reg     <= clk_div_next;
      rise_reg        <= rise_next;
      fall_reg        <= fall_next;
      period_end_reg  <= period_end_next;
    end
  end

  assign ctrl.clk_div     = clk_div_reg;
  assign ctrl.rise        = rise_reg;
  assign ctrl.fall        = fall_reg;
  assign ctrl.period_end  = period_end_reg;
  assign ctrl.cfg_pending = pending_reg;
  assign ctrl.active      = (state_reg == ST_RUN);
endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: constant vector table, directed corner sequences,
// and randomized traffic against a behavioural model of the divider.
`timescale 1ns/1ps
module tb_clk_div_prog;
  localparam int CW = 16;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  clk_div_prog_if #(.P_CNT_W(CW)) bus ();

  clk_div_prog #(
    .P_CNT_W(CW), .P_DIV_DEFAULT(4), .P_HIGH_DEFAULT(2), .P_EN_DEFAULT(1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .ctrl (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: position within the current period plus the active,
  // shadow and pending configuration.
  bit       m_act, m_pend, m_start, m_prev;
  int       m_pos, m_n, m_h, m_sn, m_sh;
  bit [5:0] m_exp;

  task automatic model_reset();
    m_act = 0; m_pend = 0; m_start = 1; m_prev = 0;
    m_pos = 0; m_n = 4; m_h = 2; m_sn = 4; m_sh = 2;
    m_exp = '0;
  endtask

  task automatic model_edge(input bit en, input bit load, input int dv, input int hv);
    bit end_of_period;
    bit take;
    int nn;
    int hh;
    bit e_clk, e_rise, e_fall, e_pe;
    end_of_period = m_act && (m_pos == m_n - 1);
    take = m_pend && !load && (!m_act || end_of_period);
    nn = (dv < 2) ? 2 : dv;
    hh = (hv > nn) ? nn : hv;
    if (take) begin
      m_n = m_sn; m_h = m_sh; m_pend = 0;
    end
    if (load) begin
      m_sn = nn; m_sh = hh; m_pend = 1;
    end
    if (m_act) begin
      if (end_of_period) begin
        m_act = en; m_pos = 0;
      end else begin
        m_pos = m_pos + 1;
      end
    end else if (m_start && en) begin
      m_act = 1; m_pos = 0;
    end
    m_start = en;
    e_clk  = m_act && (m_pos < m_h);
    e_rise = m_act && (m_pos == 0) && (m_h > 0) && !m_prev;
    e_fall = m_act && (m_h > 0) && (m_h < m_n) && (m_pos == m_h);
    e_pe   = m_act && (m_pos == m_n - 1);
    m_prev = e_clk;
    m_exp  = {e_clk, e_rise, e_fall, e_pe, m_pend, m_act};
  endtask

  function automatic logic [5:0] dut_vec();
    return {bus.clk_div, bus.rise, bus.fall, bus.period_end, bus.cfg_pending, bus.active};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  task automatic drive(input bit en, input bit load, input int dv, input int hv);
    bus.en       = en;
    bus.cfg_load = load;
    bus.cfg_div  = CW'(dv);
    bus.cfg_high = CW'(hv);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge(bus.en, bus.cfg_load, int'(bus.cfg_div), int'(bus.cfg_high));
    chk(tag, 32'(dut_vec()), 32'(m_exp));
  endtask

  task automatic load_pulse(input bit en, input int dv, input int hv);
    drive(en, 1'b1, dv, hv);
    step("load");
    drive(en, 1'b0, dv, hv);
  endtask

  task automatic seek(input int n, input int pos);
    bit ok;
    ok = (m_act && m_n == n && m_pos == pos);
    for (int k = 0; k < 60 && !ok; k++) begin
      step("seek");
      ok = (m_act && m_n == n && m_pos == pos);
    end
    chk("seek_reached", 32'(ok), 32'd1);
  endtask

  typedef struct {
    bit       en;
    bit       load;
    int       dv;
    int       hv;
    logic [5:0] exp;   // {clk_div, rise, fall, period_end, cfg_pending, active}
  } vec_t;

  vec_t tbl [25];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_act, rises, falls, highs, lows;
    bit idle;

    // Defaults 4/2, then a load at cnt=1, a load at a period end, a load at cnt=3.
    tbl[0]  = '{1'b1, 1'b0, 0, 0, 6'b110001};
    tbl[1]  = '{1'b1, 1'b0, 0, 0, 6'b100001};
    tbl[2]  = '{1'b1, 1'b1, 6, 3, 6'b001011};
    tbl[3]  = '{1'b1, 1'b0, 0, 0, 6'b000111};
    tbl[4]  = '{1'b1, 1'b0, 0, 0, 6'b110001};
    tbl[5]  = '{1'b1, 1'b0, 0, 0, 6'b100001};
    tbl[6]  = '{1'b1, 1'b0, 0, 0, 6'b100001};
    tbl[7]  = '{1'b1, 1'b0, 0, 0, 6'b001001};
    tbl[8]  = '{1'b1, 1'b0, 0, 0, 6'b000001};
    tbl[9]  = '{1'b1, 1'b0, 0, 0, 6'b000101};
    tbl[10] = '{1'b1, 1'b1, 4, 2, 6'b110011};
    tbl[11] = '{1'b1, 1'b0, 0, 0, 6'b100011};
    tbl[12] = '{1'b1, 1'b0, 0, 0, 6'b100011};
    tbl[13] = '{1'b1, 1'b0, 0, 0, 6'b001011};
    tbl[14] = '{1'b1, 1'b0, 0, 0, 6'b000011};
    tbl[15] = '{1'b1, 1'b0, 0, 0, 6'b000111};
    tbl[16] = '{1'b1, 1'b0, 0, 0, 6'b110001};
    tbl[17] = '{1'b1, 1'b0, 0, 0, 6'b100001};
    tbl[18] = '{1'b1, 1'b0, 0, 0, 6'b001001};
    tbl[19] = '{1'b1, 1'b0, 0, 0, 6'b000101};
    tbl[20] = '{1'b1, 1'b1, 6, 3, 6'b110011};
    tbl[21] = '{1'b1, 1'b0, 0, 0, 6'b100011};
    tbl[22] = '{1'b1, 1'b0, 0, 0, 6'b001011};
    tbl[23] = '{1'b1, 1'b0, 0, 0, 6'b000111};
    tbl[24] = '{1'b1, 1'b0, 0, 0, 6'b110001};

    rst = 1'b1;
    drive(1'b1, 1'b0, 0, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_state", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].en, tbl[i].load, tbl[i].dv, tbl[i].hv);
      step("tbl_model");
      chk($sformatf("tbl_row%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end
    drive(1'b1, 1'b0, 0, 0);

    // Odd ratio loaded while idle.
    drive(1'b0, 1'b0, 0, 0);
    idle = 0;
    for (int k = 0; k < 20 && !idle; k++) begin
      step("drain");
      idle = !bus.active;
    end
    chk("drain_idle", 32'(idle), 32'd1);
    load_pulse(1'b0, 5, 2);
    chk("idle_pending_set", 32'(bus.cfg_pending), 32'd1);
    step("idle_apply");
    chk("idle_pending_clr", 32'(bus.cfg_pending), 32'd0);
    drive(1'b1, 1'b0, 0, 0);
    step("start_wait");
    chk("start_latency", 32'(bus.active), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step("odd");
      chk($sformatf("odd_clk%0d", i), 32'(bus.clk_div), 32'((i % 5) < 2));
    end

    // Stop at cnt=1 of N=8 runs the period out, then restart.
    load_pulse(1'b1, 8, 4);
    seek(8, 1);
    drive(1'b0, 1'b0, 0, 0);
    n_act = 0;
    idle = 0;
    for (int k = 0; k < 20 && !idle; k++) begin
      step("stop");
      if (bus.active) n_act++;
      else idle = 1;
    end
    chk("stop_tail_len", 32'(n_act), 32'd6);
    chk("stop_clk_low", 32'(bus.clk_div), 32'd0);
    drive(1'b1, 1'b0, 0, 0);
    step("restart_wait");
    chk("restart_latency", 32'(bus.active), 32'd0);
    step("restart");
    chk("restart_active", 32'({bus.active, bus.clk_div}), 32'd3);
    seek(8, 2);
    drive(1'b0, 1'b0, 0, 0);
    step("toggle");
    step("toggle");
    drive(1'b1, 1'b0, 0, 0);
    lows = 0;
    for (int k = 0; k < 16; k++) begin
      step("toggle");
      if (!bus.active) lows++;
    end
    chk("toggle_no_gap", 32'(lows), 32'd0);

    // Clamping extremes.
    load_pulse(1'b1, 0, 0);
    for (int k = 0; k < 20 && bus.cfg_pending; k++) step("clamp0_wait");
    chk("clamp0_applied", 32'(bus.cfg_pending), 32'd0);
    highs = 0; rises = 0; falls = 0;
    for (int k = 0; k < 12; k++) begin
      step("clamp0");
      highs += bus.clk_div; rises += bus.rise; falls += bus.fall;
    end
    chk("clamp0_strobes", 32'({highs[7:0], rises[7:0], falls[7:0]}), 32'd0);
    load_pulse(1'b1, 3, 7);
    rises = 0; falls = 0; lows = 0;
    for (int k = 0; k < 20 && bus.cfg_pending; k++) begin
      step("clamp3_wait");
      rises += bus.rise; falls += bus.fall;
    end
    for (int k = 0; k < 12; k++) begin
      step("clamp3");
      rises += bus.rise; falls += bus.fall;
      if (!bus.clk_div) lows++;
    end
    chk("clamp3_rise_once", 32'(rises), 32'd1);
    chk("clamp3_no_fall", 32'(falls), 32'd0);
    chk("clamp3_const_high", 32'(lows), 32'd0);

    // Asynchronous reset in the high phase of N=10/H=5.
    load_pulse(1'b1, 10, 5);
    seek(10, 2);
    chk("arst_pre_high", 32'(bus.clk_div), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_clk_low", 32'(bus.clk_div), 32'd0);
    chk("arst_outputs", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step("arst_restart");
    chk("arst_defaults", 32'(dut_vec()), 32'h31);
    for (int k = 0; k < 7; k++) step("arst_run");

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
            int'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable clock divider/strobe generator; successor to the fixed even-ratio divider used for LED/peripheral timing.
- Generates a divided "clock" of any period N ≥ 2 and any high time H (0..N), so odd ratios and non-50% duty are supported.
- Emits single-cycle rise/fall/period-end strobes for use as clock enables in the i_clk domain.
- Divide ratio and duty change safely at a period boundary, with start/stop control.

Parameters:
- P_CNT_W, 16, counter and config width in bits (2..32).
- P_DIV_DEFAULT, 2, period N loaded at reset (2..2^P_CNT_W-1).
- P_HIGH_DEFAULT, 1, high time H loaded at reset. P_DIV_DEFAULT/2 reproduces the legacy 50% even divider.
- P_EN_DEFAULT, 1, reset value of the internal run state (1 = run from reset while i_en = 1).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_en  in  1  run request, level
- i_cfg_load  in  1  one-cycle pulse; captures i_cfg_div/i_cfg_high into shadow
- i_cfg_div  in  P_CNT_W  requested period N in i_clk cycles
- i_cfg_high  in  P_CNT_W  requested high time H in i_clk cycles
- o_clk_div  out  1  divided output, registered
- o_rise  out  1  strobe, first high cycle of a period
- o_fall  out  1  strobe, first low cycle after a high phase
- o_period_end  out  1  strobe, last cycle of a period
- o_cfg_pending  out  1  shadow config not yet applied
- o_active  out  1  divider running

Behaviour:
- Reset (async, i_rst=1):
  - cnt=0; active N/H = defaults; shadow = defaults; all outputs 0.
  - Run state = P_EN_DEFAULT. With P_EN_DEFAULT=1, a period starts on the first clock after reset release if i_en=1.
- Clamping at capture:
  - i_cfg_div < 2 is stored as 2.
  - i_cfg_high > N is stored as N.
- Counter:
  - While active, cnt runs 0..N-1 and wraps to 0.
  - The cycle with cnt = N-1 is the period end.
- Output:
  - o_clk_div = 1 in cycles where cnt < H, else 0. It is registered from next-count logic, with no combinational path from inputs.
  - H=0 gives constant low; o_rise/o_fall never assert.
  - H=N gives constant high; o_rise asserts once at start, o_fall never.
- Strobes, each exactly 1 cycle:
  - o_rise: in cycle cnt=0 when H>0 and the previous cycle's o_clk_div was 0.
  - o_fall: in cycle cnt=H when 0<H<N.
  - o_period_end: in cycle cnt=N-1.
- Start:
  - While idle, i_en=1 sampled at edge k makes the active state (o_active=1, cnt=0, o_clk_div=(H>0)) visible after edge k+1.
  - Start latency is 1 cycle.
- Stop:
  - i_en=0 does not truncate the current period. After the cycle with o_period_end=1, the block goes idle: o_active=0, cnt=0, o_clk_div=0.
  - If i_en returns to 1 before the period end, the block continues seamlessly with no gap.
- Config handshake:
  - i_cfg_load=1 captures the shadow and sets o_cfg_pending=1.
  - While active, the shadow becomes the active N/H at the wrap after the next period end; o_cfg_pending clears on that same edge. The new period starts with the new values, and no period mixes old and new N/H.
  - While idle, the shadow applies on the next edge, and o_cfg_pending is 1 for exactly one cycle.
  - A load while pending overwrites the shadow (last write wins).
  - A load in the same cycle as a period end is not applied at that boundary; it applies at the following boundary.
- Width: all comparisons are unsigned P_CNT_W. No wrap-around except cnt N-1→0.
- Reset mid-period: output drops to 0 immediately (async); no strobe is emitted on reset.

Test Plan:
- Reset defaults: P_DIV_DEFAULT=4, P_HIGH_DEFAULT=2, i_en=1 → o_clk_div pattern 1100 repeating; o_rise at cnt=0, o_fall at cnt=2, o_period_end at cnt=3.
- Odd ratio: load N=5, H=2 while idle → after 1 cycle pattern 11000 repeating; o_cfg_pending high for exactly 1 cycle.
- Boundary update: running N=4/H=2, load N=6/H=3 at cnt=1 → current period completes as 1100, then 111000; o_cfg_pending clears at the wrap. Separately, load at cnt=3 → one more 1100 period before the change.
- Clamping and extremes: load N=0,H=0 → N=2, output constant 0, no rise/fall strobes. Load N=3,H=7 → H=3, constant 1, o_rise once, no o_fall.
- Stop/restart: i_en=0 at cnt=1 of N=8 → period runs to cnt=7, then o_active=0 and o_clk_div=0. i_en=1 again → o_active=1 and o_clk_div=1 one cycle later. Toggling i_en 0→1 within a period shows no gap.
- Async reset mid-high phase with N=10, H=5, cnt=2 → o_clk_div=0 with no clock edge. After release, the block restarts from the defaults.
